// File: rtl/match_action_issuer.sv
// match_action_issuer: two-stage exact-match table lookup that issues action_id/action_data aligned with each packet beat.
// Optional hit/miss counters are built only when MATCH_ACTION_ISSUER_STATS_EN is defined; otherwise both read 0.
module match_action_issuer #(
    parameter int DATA_WIDTH = 512,
    parameter int KEY_WIDTH = 32,
    parameter int ACTION_DATA_WIDTH = 128,
    parameter int TABLE_DEPTH = 16,
    parameter logic [2:0] DEFAULT_ACTION_ID = 3'd1
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [DATA_WIDTH-1:0]          packet_in,
    input  logic [KEY_WIDTH-1:0]           lookup_key,
    input  logic                           packet_valid,
    output logic                           packet_ready,
    output logic [DATA_WIDTH-1:0]          packet_out,
    output logic                           packet_out_valid,
    input  logic                           packet_out_ready,
    output logic [2:0]                     action_id,
    output logic [ACTION_DATA_WIDTH-1:0]   action_data,
    output logic                           action_valid,
    output logic                           lookup_hit,
    input  logic                           tbl_wr_en,
    input  logic [$clog2(TABLE_DEPTH)-1:0] tbl_wr_idx,
    input  logic                           tbl_wr_entry_valid,
    input  logic [KEY_WIDTH-1:0]           tbl_wr_key,
    input  logic [2:0]                     tbl_wr_action_id,
    input  logic [ACTION_DATA_WIDTH-1:0]   tbl_wr_action_data,
    input  logic                           tbl_clear,
    output logic [31:0]                    hit_count,
    output logic [31:0]                    miss_count
);
    localparam int IW = $clog2(TABLE_DEPTH);
    logic                         r_s1_valid;
    logic [DATA_WIDTH-1:0]        r_s1_data;
    logic [KEY_WIDTH-1:0]         r_s1_key;
    logic [TABLE_DEPTH-1:0]       r_ent_valid;
    logic [KEY_WIDTH-1:0]         r_ent_key [TABLE_DEPTH];
    logic [2:0]                   r_ent_id [TABLE_DEPTH];
    logic [ACTION_DATA_WIDTH-1:0] r_ent_data [TABLE_DEPTH];
    logic                         w_stall;
    logic                         w_hit;
    logic [IW-1:0]                w_idx;

    assign w_stall = packet_out_valid && !packet_out_ready;
    assign packet_ready = !w_stall;
    assign action_valid = packet_out_valid;

    always_ff @(posedge aclk) begin
        if (areset)
            r_s1_valid <= 1'b0;
        else if (!w_stall)
            r_s1_valid <= packet_valid;
    end

    always_ff @(posedge aclk) begin
        if (!w_stall && packet_valid) begin
            r_s1_data <= packet_in;
            r_s1_key  <= lookup_key;
        end
    end

    // Descending scan so the lowest matching index is the last assignment and wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (r_ent_valid[i] && r_ent_key[i] == r_s1_key) begin
                w_hit = 1'b1;
                w_idx = i[IW-1:0];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            packet_out_valid <= 1'b0;
            packet_out       <= '0;
            action_id        <= '0;
            action_data      <= '0;
            lookup_hit       <= 1'b0;
        end else if (!w_stall) begin
            packet_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                packet_out  <= r_s1_data;
                action_id   <= w_hit ? r_ent_id[w_idx] : DEFAULT_ACTION_ID;
                action_data <= w_hit ? r_ent_data[w_idx] : '0;
                lookup_hit  <= w_hit;
            end
        end
    end

    // Clear beats a same-cycle write, so the written entry stays invalid.
    always_ff @(posedge aclk) begin
        if (areset || tbl_clear)
            r_ent_valid <= '0;
        else if (tbl_wr_en)
            r_ent_valid[tbl_wr_idx] <= tbl_wr_entry_valid;
    end

    always_ff @(posedge aclk) begin
        if (tbl_wr_en && !tbl_clear) begin
            r_ent_key[tbl_wr_idx]  <= tbl_wr_key;
            r_ent_id[tbl_wr_idx]   <= tbl_wr_action_id;
            r_ent_data[tbl_wr_idx] <= tbl_wr_action_data;
        end
    end

`ifdef MATCH_ACTION_ISSUER_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_s1_valid && !w_stall) begin
            if (w_hit && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (!w_hit && r_miss_cnt != '1)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_match_action_issuer.sv
// tb_match_action_issuer: scoreboard bench for match_action_issuer; lookup vectors, stall, clear and reset sequences.
module tb_match_action_issuer;
`ifdef MATCH_ACTION_ISSUER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [511:0] pkt;
        logic [2:0]   id;
        logic [127:0] data;
        logic         hit;
    } exp_t;

    typedef struct {
        logic [31:0]  key;
        logic [2:0]   id;
        logic [127:0] data;
        logic         hit;
    } vec_t;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [511:0] packet_in = '0;
    logic [31:0]  lookup_key = '0;
    logic         packet_valid = 1'b0;
    logic         packet_ready;
    logic [511:0] packet_out;
    logic         packet_out_valid;
    logic         packet_out_ready = 1'b1;
    logic [2:0]   action_id;
    logic [127:0] action_data;
    logic         action_valid;
    logic         lookup_hit;
    logic         tbl_wr_en = 1'b0;
    logic [3:0]   tbl_wr_idx = '0;
    logic         tbl_wr_entry_valid = 1'b0;
    logic [31:0]  tbl_wr_key = '0;
    logic [2:0]   tbl_wr_action_id = '0;
    logic [127:0] tbl_wr_action_data = '0;
    logic         tbl_clear = 1'b0;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int total = 0;
    int bad = 0;
    int n_out = 0;
    int m_hits = 0;
    int m_misses = 0;
    exp_t sb[$];
    logic         m_valid [16];
    logic [31:0]  m_key [16];
    logic [2:0]   m_id [16];
    logic [127:0] m_data [16];

    logic         prev_stall = 1'b0;
    logic [511:0] p_pkt;
    logic [2:0]   p_id;
    logic [127:0] p_data;
    logic         p_hit;

    match_action_issuer dut (
        .aclk(aclk), .areset(areset), .packet_in(packet_in), .lookup_key(lookup_key),
        .packet_valid(packet_valid), .packet_ready(packet_ready), .packet_out(packet_out),
        .packet_out_valid(packet_out_valid), .packet_out_ready(packet_out_ready),
        .action_id(action_id), .action_data(action_data), .action_valid(action_valid),
        .lookup_hit(lookup_hit), .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx),
        .tbl_wr_entry_valid(tbl_wr_entry_valid), .tbl_wr_key(tbl_wr_key),
        .tbl_wr_action_id(tbl_wr_action_id), .tbl_wr_action_data(tbl_wr_action_data),
        .tbl_clear(tbl_clear), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [511:0] r512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference lookup: first valid entry in ascending index order.
    function automatic exp_t model(input logic [31:0] k, input logic [511:0] d);
        exp_t e;
        logic found;
        e.pkt = d; e.id = 3'd1; e.data = '0; e.hit = 1'b0; found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && m_valid[i] && m_key[i] == k) begin
                found = 1'b1; e.hit = 1'b1; e.id = m_id[i]; e.data = m_data[i];
            end
        end
        return e;
    endfunction

    always @(negedge aclk) begin
        exp_t e;
        if (areset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (packet_out !== p_pkt || action_id !== p_id || action_data !== p_data ||
                    lookup_hit !== p_hit || packet_out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold: got id=%0h hit=%0b v=%0b want id=%0h hit=%0b v=1",
                             action_id, lookup_hit, packet_out_valid, p_id, p_hit);
                end
            end
            if (packet_out_valid && !packet_out_ready) chk("stall_ready", packet_ready, 1'b0);
            if (packet_out_valid && packet_out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got pkt=%0h want none", packet_out[63:0]);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    if (packet_out !== e.pkt || action_id !== e.id || action_data !== e.data ||
                        lookup_hit !== e.hit || action_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL beat%0d: got pkt=%0h id=%0h data=%0h hit=%0b av=%0b want pkt=%0h id=%0h data=%0h hit=%0b av=1",
                                 n_out, packet_out[63:0], action_id, action_data, lookup_hit, action_valid,
                                 e.pkt[63:0], e.id, e.data, e.hit);
                    end
                end
            end
            prev_stall = packet_out_valid && !packet_out_ready;
            p_pkt = packet_out; p_id = action_id; p_data = action_data; p_hit = lookup_hit;
        end
    end

    task automatic send(input logic [31:0] k, input logic [511:0] d, input exp_t e);
        logic done;
        done = 1'b0;
        packet_valid = 1'b1; lookup_key = k; packet_in = d;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge aclk);
            if (packet_ready && !areset) begin
                sb.push_back(e);
                if (e.hit) m_hits++; else m_misses++;
                done = 1'b1;
            end
            @(posedge aclk); #1;
        end
        packet_valid = 1'b0;
        if (!done) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_m(input logic [31:0] k);
        logic [511:0] d;
        d = r512();
        send(k, d, model(k, d));
    endtask

    task automatic send_c(input logic [31:0] k, input logic [2:0] id, input logic [127:0] data, input logic hit);
        exp_t e;
        e.pkt = r512(); e.id = id; e.data = data; e.hit = hit;
        send(k, e.pkt, e);
    endtask

    task automatic wr(input int idx, input logic v, input logic [31:0] k, input logic [2:0] id, input logic [127:0] data);
        tbl_wr_en = 1'b1; tbl_wr_idx = idx[3:0]; tbl_wr_entry_valid = v;
        tbl_wr_key = k; tbl_wr_action_id = id; tbl_wr_action_data = data;
        @(posedge aclk); #1;
        tbl_wr_en = 1'b0;
        m_valid[idx] = v; m_key[idx] = k; m_id[idx] = id; m_data[idx] = data;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(posedge aclk);
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_hits"}, hit_count, STATS ? 128'(m_hits) : 128'd0);
        chk({name, "_misses"}, miss_count, STATS ? 128'(m_misses) : 128'd0);
    endtask

    vec_t vecs[8];
    int base;

    initial begin
        vecs[0] = '{32'h1111_1111, 3'd2, 128'hAAAA, 1'b1};
        vecs[1] = '{32'h2222_2222, 3'd3, 128'hBBBB, 1'b1};
        vecs[2] = '{32'h3333_3333, 3'd7, {128{1'b1}}, 1'b1};
        vecs[3] = '{32'h4444_4444, 3'd1, 128'h0, 1'b0};
        vecs[4] = '{32'h0A00_0001, 3'd0, 128'h1_0000_0000_AB, 1'b1};
        vecs[5] = '{32'hC0A8_0001, 3'd5, 128'h55, 1'b1};
        vecs[6] = '{32'h1234_5678, 3'd1, 128'h0, 1'b0};
        vecs[7] = '{32'h0000_0000, 3'd1, 128'h0, 1'b0};
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_valid", packet_out_valid, 1'b0);
        chk("rst_action_valid", action_valid, 1'b0);
        chk("rst_id", action_id, 3'd0);
        chk("rst_data", action_data, 128'd0);
        chk("rst_hit", lookup_hit, 1'b0);
        chk("rst_pkt", packet_out[127:0], 128'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        @(posedge aclk); #1 areset = 1'b0;

        // Empty-table miss plus two-cycle latency.
        send_c(32'h0A00_0001, 3'd1, 128'd0, 1'b0);
        @(negedge aclk);
        chk("lat_cycle1", packet_out_valid, 1'b0);
        @(negedge aclk);
        chk("lat_cycle2", packet_out_valid, 1'b1);
        drain();
        chk_cnt("miss1");

        wr(3, 1'b1, 32'h0A00_0001, 3'd0, 128'h1_0000_0000_AB);
        send_c(32'h0A00_0001, 3'd0, 128'h1_0000_0000_AB, 1'b1);
        drain();
        chk_cnt("hit1");

        wr(5, 1'b1, 32'hC0A8_0001, 3'd5, 128'h55);
        wr(2, 1'b1, 32'hC0A8_0001, 3'd0, 128'h22);
        send_c(32'hC0A8_0001, 3'd0, 128'h22, 1'b1);
        drain();
        wr(2, 1'b0, 32'hC0A8_0001, 3'd0, 128'h22);
        send_c(32'hC0A8_0001, 3'd5, 128'h55, 1'b1);
        drain();

        wr(0, 1'b1, 32'h1111_1111, 3'd2, 128'hAAAA);
        wr(7, 1'b1, 32'h2222_2222, 3'd3, 128'hBBBB);
        wr(15, 1'b1, 32'h3333_3333, 3'd7, {128{1'b1}});
        wr(9, 1'b0, 32'h4444_4444, 3'd6, 128'h99);
        for (int i = 0; i < 8; i++) send_c(vecs[i].key, vecs[i].id, vecs[i].data, vecs[i].hit);
        drain();
        chk_cnt("vecs");

        // Back-to-back stream with a 3-cycle downstream stall.
        base = n_out;
        fork
            for (int i = 0; i < 8; i++) send_m(i[0] ? 32'h2222_2222 : 32'h7777_0000 + 32'(i));
            begin
                repeat (3) @(posedge aclk);
                #1 packet_out_ready = 1'b0;
                repeat (3) @(posedge aclk);
                #1 packet_out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_beats", 32'(n_out - base), 32'd8);
        chk_cnt("stream");

        tbl_clear = 1'b1;
        wr(4, 1'b1, 32'h5555_5555, 3'd4, 128'h44);
        tbl_clear = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        send_c(32'h5555_5555, 3'd1, 128'd0, 1'b0);
        send_c(32'h1111_1111, 3'd1, 128'd0, 1'b0);
        drain();

        // Reset with one beat held in S2 and one in S1.
        packet_out_ready = 1'b0;
        send_m(32'h2222_2222);
        send_m(32'h1234_0000);
        areset = 1'b1;
        m_hits = 0; m_misses = 0;
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst_mid_valid", packet_out_valid, 1'b0);
        chk_cnt("rst_mid");
        packet_out_ready = 1'b1;
        base = n_out;
        repeat (6) @(posedge aclk);
        #1;
        chk("rst_mid_no_stale", 32'(n_out - base), 32'd0);
        chk("rst_mid_valid_late", packet_out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
